sccb_write_master: RTL

//  Bit-level SCCB (I2C-compatible) 3-phase write engine driving OV7670 SIOC/SIOD.

---
 rtl/sccb_write_master_pkg.sv | 32 +++
 rtl/sccb_tick_gen.sv | 37 +++
 rtl/sccb_write_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sccb_write_master_pkg.sv
// Shared constants for the SCCB write engine: FSM encodings, quarter codes,
// frame geometry and the frame packing helper.
package sccb_write_master_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BIT   = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BUF   = 3'd4;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int NBITS  = 27;   // 3 bytes, each followed by a don't-care bit
  localparam int NSLOTS = 30;   // START + 27 bits + STOP + BUF

  localparam logic [7:0] OV7670_ID = 8'h42;

  // The don't-care (9th) positions are loaded as 1 so the line is released.
  function automatic logic [NBITS-1:0] sccb_frame(input logic [7:0] dev,
                                                  input logic [7:0] rg,
                                                  input logic [7:0] dat);
    return {dev, 1'b1, rg, 1'b1, dat, 1'b1};
  endfunction

  function automatic logic is_ninth(input logic [4:0] idx);
    return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
  endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit timebase: counts 0..QDIV-1, pulses qtick on the last count and
// steps a 2-bit quarter index. Synchronous clear restarts both at zero.
module sccb_tick_gen #(
  parameter int QDIV = 62
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  output logic       qtick_o,
  output logic [1:0] quarter_o
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [1:0]    qtr_q;

  assign qtick_o   = (cnt_q == CW'(QDIV - 1));
  assign quarter_o = qtr_q;

  // Divider and quarter index; clear wins over the tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      qtr_q <= 2'd0;
    end else if (clr_i) begin
      cnt_q <= '0;
      qtr_q <= 2'd0;
    end else if (qtick_o) begin
      cnt_q <= '0;
      qtr_q <= qtr_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write engine: START, 27 bit slots {dev,Z,reg,Z,data,Z}, STOP,
// then one bus-free slot. Pins are registered from the current phase, so they
// trail the phase by one clock; slot length and order are unaffected.
module sccb_write_master
  import sccb_write_master_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int SCL_HZ    = 100_000,
  parameter bit CHECK_ACK = 1'b1
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       start,
  input  logic [7:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       sioc,
  output logic       siod_oe,
  input  logic       siod_in
);

  localparam int QDIV = CLK_HZ / (4 * SCL_HZ);

  logic             qtick, tick_clr;
  logic [1:0]       quarter;
  logic [2:0]       state_q, state_d;
  logic [4:0]       bit_q, bit_d, slot_q, slot_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic             busy_q, done_q, done_d, ack_q, ack_d;
  logic             sioc_q, sioc_d, oe_q, oe_d;
  logic [1:0]       sync_q;
  logic             accept, slot_end, ninth, nack_seen;

  // A start in the done cycle is dropped: busy is already low there.
  assign accept    = start & ~busy_q & ~done_q;
  assign slot_end  = qtick & (quarter == Q3);
  assign ninth     = is_ninth(bit_q);
  assign tick_clr  = (state_q == ST_IDLE);
  assign nack_seen = CHECK_ACK && (state_q == ST_BIT) && ninth &&
                     qtick && (quarter == Q2) && sync_q[1];

  sccb_tick_gen #(.QDIV(QDIV)) u_tick (
    .clk_i     (iCLK),
    .rst_ni    (iRST_N),
    .clr_i     (tick_clr),
    .qtick_o   (qtick),
    .quarter_o (quarter)
  );

  // Phase sequencing: one state per slot, shift register advances per bit.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    sr_d    = sr_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_START;
        sr_d    = sccb_frame(dev_addr, reg_addr, reg_data);
        slot_d  = 5'd0;
        bit_d   = 5'd0;
      end
      ST_START: if (slot_end) begin
        state_d = ST_BIT;
        slot_d  = slot_q + 5'd1;
      end
      ST_BIT: if (slot_end) begin
        slot_d = slot_q + 5'd1;
        sr_d   = {sr_q[NBITS-2:0], 1'b1};
        if (bit_q == 5'(NBITS - 1)) state_d = ST_STOP;
        else                        bit_d   = bit_q + 5'd1;
      end
      ST_STOP: if (slot_end) begin
        state_d = ST_BUF;
        slot_d  = slot_q + 5'd1;
      end
      ST_BUF: if (slot_end && slot_q == 5'(NSLOTS - 1)) begin
        state_d = ST_IDLE;
        slot_d  = 5'd0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky NACK flag, cleared on every accepted request.
  always_comb begin
    ack_d = ack_q;
    if (accept)         ack_d = 1'b0;
    else if (nack_seen) ack_d = 1'b1;
  end

  // Pin levels for the current phase; SIOD only moves with SIOC low in bits.
  always_comb begin
    sioc_d = 1'b1;
    oe_d   = 1'b0;
    unique case (state_q)
      ST_START: begin
        sioc_d = (quarter != Q3);
        oe_d   = (quarter == Q2) || (quarter == Q3);
      end
      ST_BIT: begin
        sioc_d = (quarter == Q1) || (quarter == Q2);
        oe_d   = ninth ? 1'b0 : ~sr_q[NBITS-1];
      end
      ST_STOP: begin
        sioc_d = (quarter != Q0);
        oe_d   = (quarter == Q0) || (quarter == Q1);
      end
      default: begin
        sioc_d = 1'b1;
        oe_d   = 1'b0;
      end
    endcase
  end

  // State, data path and registered pin drivers; reset releases the bus.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      bit_q   <= 5'd0;
      slot_q  <= 5'd0;
      sr_q    <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      sioc_q  <= 1'b1;
      oe_q    <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      sr_q    <= sr_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      ack_q   <= ack_d;
      sioc_q  <= sioc_d;
      oe_q    <= oe_d;
      sync_q  <= {sync_q[0], siod_in};
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_q;
  assign sioc    = sioc_q;
  assign siod_oe = oe_q;

endmodule
